// File: rtl/keypad_display.sv
// keypad_display: 12-key keypad entry shown right-aligned on an 8-digit multiplexed 7-segment display
// Optional input debouncing is enabled by defining KEYPAD_DEBOUNCE_EN.
module keypad_display #(
    parameter int SCAN_DIV = 4,
    parameter int DEB_CYC  = 2
) (
    input  logic        iCLK,
    input  logic        nRST,
    input  logic [11:0] iKeypad,
    output logic [7:0]  oS_COM,
    output logic [7:0]  oS_ENS
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [9:0][7:0] SEG = {8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D,
                                       8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F};

    logic [7:0][3:0] slots, slotsNext;
    logic [11:0]     keyVec, kprev;
    logic [CW-1:0]   scanCnt, cntNext;
    logic [2:0]      scanIdx, idxNext;
    logic [3:0]      keyCode;
    logic            accept, wrap;

    function automatic logic [7:0] segOf(input logic [3:0] c);
        return (c < 4'd10) ? SEG[c] : 8'h00;
    endfunction

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYC + 1);
    logic [11:0]   debSample, debOut;
    logic [DW-1:0] debCnt;

    // A key vector is only passed on once it has been sampled unchanged DEB_CYC times in a row
    always_ff @(posedge iCLK) begin
        if (nRST) begin
            debSample <= '0;
            debCnt    <= '0;
            debOut    <= '0;
        end else begin
            debSample <= iKeypad;
            debCnt    <= (iKeypad != debSample) ? DW'(1) :
                         (debCnt == DW'(DEB_CYC)) ? debCnt : debCnt + 1'b1;
            if (debCnt == DW'(DEB_CYC))
                debOut <= debSample;
        end
    end

    assign keyVec = debOut;
`else
    assign keyVec = iKeypad;
`endif

    // Accept a single key on its press edge and work out how the digit buffer changes
    always_comb begin
        accept  = (kprev == '0) && (keyVec != '0) && ((keyVec & (keyVec - 1'b1)) == '0);
        keyCode = 4'hF;
        for (int b = 0; b < 9; b++)
            if (keyVec[b]) keyCode = 4'(b + 1);
        if (keyVec[10]) keyCode = 4'd0;
        slotsNext = !accept   ? slots :
                    keyVec[9] ? '1 :
                    keyVec[11] ? {4'hF, slots[7:1]} : {slots[6:0], keyCode};
    end

    // Scan timing: dwell SCAN_DIV cycles per digit, then move one digit to the left
    always_comb begin
        wrap    = (scanCnt == CW'(SCAN_DIV - 1));
        cntNext = wrap ? '0 : scanCnt + 1'b1;
        idxNext = wrap ? scanIdx + 3'd1 : scanIdx;
    end

    // Outputs are computed from next-state values so digit select and segments always match
    always_ff @(posedge iCLK) begin
        if (nRST) begin
            slots   <= '1;
            kprev   <= '0;
            scanCnt <= '0;
            scanIdx <= '0;
            oS_COM  <= 8'h01;
            oS_ENS  <= 8'h00;
        end else begin
            slots   <= slotsNext;
            kprev   <= keyVec;
            scanCnt <= cntNext;
            scanIdx <= idxNext;
            oS_COM  <= 8'h01 << idxNext;
            oS_ENS  <= segOf(slotsNext[idxNext]);
        end
    end
endmodule

// File: tb/tb_keypad_display.sv
// tb_keypad_display: random and directed keypad sequences checked every cycle against a digit-queue model
module tb_keypad_display;
    localparam int SCAN_DIV = 4;

    logic        iCLK = 1'b0;
    logic        nRST = 1'b1;
    logic [11:0] iKeypad = '0;
    logic [7:0]  oS_COM, oS_ENS;

    keypad_display #(.SCAN_DIV(SCAN_DIV), .DEB_CYC(2)) dut (
        .iCLK(iCLK), .nRST(nRST), .iKeypad(iKeypad), .oS_COM(oS_COM), .oS_ENS(oS_ENS)
    );

    always #5 iCLK = ~iCLK;

    // Reference: typed digits, newest first; display position i shows q[i] or blank
    int          q[$];
    int          nVectors = 0;
    int          nMiscompares = 0;
    int          edges = 0;
    bit          modelValid = 0;
    logic [11:0] prevKey = '0;
    logic [7:0]  segTab[10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] expCom();
        return 8'h01 << ((edges / SCAN_DIV) % 8);
    endfunction

    function automatic logic [7:0] expEns();
        int pos = (edges / SCAN_DIV) % 8;
        return (pos < q.size()) ? segTab[q[pos]] : 8'h00;
    endfunction

    task automatic modelEdge(input logic [11:0] key, input logic rst);
        if (rst) begin
            q.delete();
            edges = 0;
            prevKey = '0;
            modelValid = 1;
            return;
        end
        if ($countones(key) == 1 && prevKey == '0) begin
            if (key[9]) q.delete();
            else if (key[11]) begin
                if (q.size() > 0) void'(q.pop_front());
            end else begin
                q.push_front(key[10] ? 0 : $clog2(key) + 1);
                if (q.size() > 8) void'(q.pop_back());
            end
        end
        prevKey = key;
        edges++;
    endtask

    task automatic step(input logic [11:0] key, input logic rst);
        @(negedge iCLK);
        if (modelValid) begin
            check("com", oS_COM, expCom());
            check("ens", oS_ENS, expEns());
        end
        iKeypad = key;
        nRST = rst;
        modelEdge(key, rst);
    endtask

    task automatic press(input logic [11:0] key, input int hold, input int gap);
        repeat (hold) step(key, 1'b0);
        repeat (gap) step(12'h000, 1'b0);
    endtask

    function automatic logic [11:0] digitKey(input int d);
        return (d == 0) ? 12'h400 : 12'h001 << (d - 1);
    endfunction

    initial begin
        int r;
        step(12'h000, 1'b1);
        step(12'h000, 1'b1);
        repeat (8 * SCAN_DIV + 2) step(12'h000, 1'b0);
        press(12'h001, 3, 2);
        press(12'h002, 3, 2);
        repeat (8 * SCAN_DIV) step(12'h000, 1'b0);
        press(12'h400, 2, 1);
        repeat (8 * SCAN_DIV) step(12'h000, 1'b0);
        press(12'h800, 2, 1);
        repeat (8 * SCAN_DIV) step(12'h000, 1'b0);
        press(12'h040, 1, 1);
        press(12'h800, 1, 1);
        press(12'h200, 1, 1);
        repeat (8 * SCAN_DIV) step(12'h000, 1'b0);
        press(12'h400, 1, 1);
        repeat (8 * SCAN_DIV) step(12'h000, 1'b0);
        for (int d = 1; d <= 9; d++) press(digitKey(d), 2, 1);
        repeat (8 * SCAN_DIV) step(12'h000, 1'b0);
        press(12'h003, 3, 1);
        repeat (8 * SCAN_DIV) step(12'h000, 1'b0);
        press(12'h800, 1, 0);
        press(12'h001, 2, 1);
        repeat (2 * 8 * SCAN_DIV + 5) step(12'h000, 1'b0);
        step(12'h000, 1'b1);
        repeat (8 * SCAN_DIV) step(12'h000, 1'b0);
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70) press(digitKey($urandom_range(0, 9)), $urandom_range(1, 4), $urandom_range(0, 2));
            else if (r < 78) press(12'h800, $urandom_range(1, 3), $urandom_range(0, 2));
            else if (r < 82) press(12'h200, $urandom_range(1, 3), $urandom_range(0, 2));
            else if (r < 92) press(12'($urandom_range(1, 4095)), $urandom_range(1, 3), $urandom_range(0, 2));
            else if (r < 98) repeat ($urandom_range(4, 40)) step(12'h000, 1'b0);
            else step(12'h000, 1'b1);
        end
        repeat (8 * SCAN_DIV + 1) step(12'h000, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end
endmodule
